// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request handshake across misses,
// and presents one instruction (or the 16'h0800 bubble) per cycle to IF/ID.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        pc_hold,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_stall,
  input  logic        imem_done,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc_add2,
  output logic        halted,
  output logic        err
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_buf, w_buf_nxt;
  logic        r_pend, w_pend_nxt;
  logic [15:0] r_pend_pc, w_pend_pc_nxt;
  logic        r_err;

  logic        w_rd, w_valid, w_halted, w_accept;
  logic [15:0] w_acc_data;
  logic [15:0] w_redir_pc;

  assign w_redir_pc = {redirect_pc[15:1], 1'b0};

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_buf_nxt     = r_buf;
    w_pend_nxt    = r_pend;
    w_pend_pc_nxt = r_pend_pc;
    w_rd          = 1'b0;
    w_valid       = 1'b0;
    w_halted      = 1'b0;
    w_accept      = 1'b0;
    w_acc_data    = imem_data;

    unique case (r_state)
      S_FETCH: begin
        w_rd = 1'b1;
        if (imem_done) begin
          if (redirect) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            w_accept = 1'b1;
          end
        end else if (imem_stall) begin
          w_state_nxt = S_WAIT;
          if (redirect) begin
            w_pend_nxt    = 1'b1;
            w_pend_pc_nxt = w_redir_pc;
          end
        end else if (redirect) begin
          w_pc_nxt = w_redir_pc;
        end
      end
      S_WAIT: begin
        w_rd = 1'b1;
        if (imem_done) begin
          // a redirect arriving with the data beats any older pending one
          if (redirect) begin
            w_pc_nxt    = w_redir_pc;
            w_pend_nxt  = 1'b0;
            w_state_nxt = S_FETCH;
          end else if (r_pend) begin
            w_pc_nxt    = r_pend_pc;
            w_pend_nxt  = 1'b0;
            w_state_nxt = S_FETCH;
          end else begin
            w_accept = 1'b1;
          end
        end else if (redirect) begin
          w_pend_nxt    = 1'b1;
          w_pend_pc_nxt = w_redir_pc;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_FETCH;
        end else begin
          w_accept   = 1'b1;
          w_acc_data = r_buf;
        end
      end
      S_HALTED: begin
        w_halted = 1'b1;
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase

    // fetch hits, miss returns and HOLD releases share one accept path
    if (w_accept) begin
      w_valid = 1'b1;
      if (pc_hold) begin
        w_buf_nxt   = w_acc_data;
        w_state_nxt = S_HOLD;
      end else if (w_acc_data[15:11] == 5'b00000) begin
        w_state_nxt = S_HALTED;
      end else begin
        w_pc_nxt    = r_pc + 16'd2;
        w_state_nxt = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_buf     <= NOP;
      r_pend    <= 1'b0;
      r_pend_pc <= RESET_PC;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_buf     <= w_buf_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_pc <= w_pend_pc_nxt;
      r_err     <= r_err | (redirect & redirect_pc[0]);
    end
  end

  assign imem_rd     = rst & w_rd;
  assign imem_addr   = r_pc;
  assign instr_valid = rst & w_valid;
  assign instr       = (rst && w_valid) ? w_acc_data : NOP;
  assign pc_add2     = r_pc + 16'd2;
  assign halted      = rst & w_halted;
  assign err         = r_err;

endmodule
